// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared FSM state and ALU operation encodings for alu_scheduler
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // Arithmetic select encodings, common to the decoder and the shared ALU.
  localparam logic [1:0] ARITH_ADD = 2'b00;
  localparam logic [1:0] ARITH_SUB = 2'b01;
  localparam logic [1:0] ARITH_MUL = 2'b10;
  localparam logic [1:0] ARITH_DIV = 2'b11;

  // Width of the EXEC hold counter; comfortably covers any MUL/DIV wait.
  localparam int CNT_W = 8;

endpackage

// File: rtl/alu_scheduler_rr_arbiter.sv
// rtl/alu_scheduler_rr_arbiter.sv - round-robin one-hot grant, searching upward from ptr with wrap
//
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index where the search starts (highest priority this round)
//   grant - one-hot winner, all-zero when req is all-zero
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [2*N-1:0] req2;
  logic [2*N-1:0] gnt2;
  logic [N-1:0]   rot;
  logic [N-1:0]   pick;

  // Rotate so that bit ptr lands at bit 0, then the lowest set bit is the winner.
  assign req2 = {req, req};
  assign rot  = N'(req2 >> ptr);
  assign pick = rot & (~rot + 1'b1);

  // Rotate the winner back; it lands in either the low or the high half.
  assign gnt2  = {{N{1'b0}}, pick} << ptr;
  assign grant = gnt2[N-1:0] | gnt2[2*N-1:N];

endmodule

// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - round-robin scheduler sharing one combinational ALU among N_REQ requesters
//
// Ports:
//   clk, reset         - clock, asynchronous active-low reset
//   req_valid/ready    - per-requester request and one-cycle accept strobe
//   req_arith_mux      - per-requester 2-bit op (ADD/SUB/MUL/DIV)
//   req_output_mux     - per-requester select, 1 = compare (NZP) result
//   req_rs, req_rt     - per-requester 8-bit operands
//   resp_valid         - one-cycle result strobe to the owning requester
//   resp_data          - shared registered result bus
//   alu_*              - operands/selects to the shared ALU, zero outside EXEC
//   alu_out            - combinational ALU result
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DIV_WAIT = 2,
  parameter int MUL_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [2*N_REQ-1:0]   req_arith_mux,
  input  logic [N_REQ-1:0]     req_output_mux,
  input  logic [8*N_REQ-1:0]   req_rs,
  input  logic [8*N_REQ-1:0]   req_rt,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [7:0]           resp_data,
  output logic [1:0]           alu_arith_mux,
  output logic                 alu_output_mux,
  output logic [7:0]           alu_rs,
  output logic [7:0]           alu_rt,
  input  logic [7:0]           alu_out
);

  localparam int               PTR_W    = $clog2(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_WAIT);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_WAIT);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [1:0]         arith_q, arith_d;
  logic               omux_q, omux_d;
  logic [7:0]         rs_q, rs_d, rt_q, rt_d;
  logic [7:0]         resp_data_q, resp_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N_REQ-1:0]   grant;
  logic [PTR_W-1:0]   sel_idx;
  logic [1:0]         sel_arith;
  logic               sel_omux;
  logic [7:0]         sel_rs, sel_rt;
  logic [CNT_W-1:0]   cnt_load;

  rr_arbiter #(.N(N_REQ), .PW(PTR_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Only IDLE accepts; since grant is already qualified by req_valid,
  // any set ready bit is a handshake.
  assign req_ready = (state_q == S_IDLE) ? grant : '0;

  // Pick the granted requester's fields out of the packed buses.
  always_comb begin
    sel_idx   = '0;
    sel_arith = '0;
    sel_omux  = 1'b0;
    sel_rs    = '0;
    sel_rt    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_idx   = PTR_W'(i);
        sel_arith = req_arith_mux[2*i +: 2];
        sel_omux  = req_output_mux[i];
        sel_rs    = req_rs[8*i +: 8];
        sel_rt    = req_rt[8*i +: 8];
      end
    end
  end

  // Compares settle in one cycle regardless of the arith field.
  always_comb begin
    cnt_load = '0;
    if (!sel_omux) begin
      case (sel_arith)
        ARITH_MUL:            cnt_load = MUL_LOAD;
        ARITH_DIV:            cnt_load = DIV_LOAD;
        ARITH_ADD, ARITH_SUB: cnt_load = '0;
        default:              cnt_load = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    arith_d     = arith_q;
    omux_d      = omux_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (|req_ready) begin
          owner_d = sel_idx;
          arith_d = sel_arith;
          omux_d  = sel_omux;
          rs_d    = sel_rs;
          rt_d    = sel_rt;
          cnt_d   = cnt_load;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          resp_data_d = alu_out;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      arith_q     <= '0;
      omux_q      <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      cnt_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      arith_q     <= arith_d;
      omux_q      <= omux_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Decoded from registered state, so the strobe is glitch-free and is
  // killed immediately by an asynchronous reset.
  always_comb begin
    resp_valid = '0;
    if (state_q == S_RESP) resp_valid[owner_q] = 1'b1;
  end

  assign resp_data      = resp_data_q;
  assign alu_arith_mux  = (state_q == S_EXEC) ? arith_q : '0;
  assign alu_output_mux = (state_q == S_EXEC) ? omux_q  : 1'b0;
  assign alu_rs         = (state_q == S_EXEC) ? rs_q    : '0;
  assign alu_rt         = (state_q == S_EXEC) ? rt_q    : '0;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - self-checking bench for alu_scheduler with behavioural ALU and scheduling model
module tb_alu_scheduler;

  localparam int N     = 4;
  localparam int DIV_W = 2;
  localparam int MUL_W = 1;

  typedef struct {
    int         owner;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_arith_mux;
  logic [N-1:0]   req_output_mux;
  logic [8*N-1:0] req_rs;
  logic [8*N-1:0] req_rt;
  logic [N-1:0]   resp_valid;
  logic [7:0]     resp_data;
  logic [1:0]     alu_arith_mux;
  logic           alu_output_mux;
  logic [7:0]     alu_rs;
  logic [7:0]     alu_rt;
  logic [7:0]     alu_out;

  logic [1:0] f_ar [N];
  logic       f_om [N];
  logic [7:0] f_rs [N];
  logic [7:0] f_rt [N];

  int n_cmp = 0;
  int n_bad = 0;

  alu_scheduler #(.N_REQ(N), .DIV_WAIT(DIV_W), .MUL_WAIT(MUL_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_arith_mux  (req_arith_mux),
    .req_output_mux (req_output_mux),
    .req_rs         (req_rs),
    .req_rt         (req_rt),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .alu_arith_mux  (alu_arith_mux),
    .alu_output_mux (alu_output_mux),
    .alu_rs         (alu_rs),
    .alu_rt         (alu_rt),
    .alu_out        (alu_out)
  );

  always #5 clk = ~clk;

  // Shared ALU: wraps mod 256; compare gives NZP one-hot (N=100, Z=010, P=001).
  function automatic logic [7:0] alu_fn(input logic [1:0] a, input logic om,
                                        input logic [7:0] rs, input logic [7:0] rt);
    if (om) return (rs > rt) ? 8'd1 : ((rs == rt) ? 8'd2 : 8'd4);
    case (a)
      2'b00:   return 8'(rs + rt);
      2'b01:   return 8'(rs - rt);
      2'b10:   return 8'(rs * rt);
      default: return (rt == 8'd0) ? 8'd0 : 8'(rs / rt);
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] a, input logic om);
    if (om) return 2;
    if (a == 2'b10) return 2 + MUL_W;
    if (a == 2'b11) return 2 + DIV_W;
    return 2;
  endfunction

  function automatic int model_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  assign alu_out = alu_fn(alu_arith_mux, alu_output_mux, alu_rs, alu_rt);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_arith_mux[2*i +: 2] = f_ar[i];
      req_output_mux[i]       = f_om[i];
      req_rs[8*i +: 8]        = f_rs[i];
      req_rt[8*i +: 8]        = f_rt[i];
    end
  end

  task automatic rand_fields(input int i);
    f_ar[i] = 2'($urandom_range(0, 3));
    f_om[i] = ($urandom_range(0, 3) == 0);
    f_rs[i] = 8'($urandom);
    f_rt[i] = ($urandom_range(0, 3) == 0) ? f_rs[i] : 8'($urandom);
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (|resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int bad_idle = 0;
    reset = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (resp_valid !== '0 || resp_data !== 8'd0 || req_ready !== '0 ||
        alu_rs !== 8'd0 || alu_rt !== 8'd0 || alu_arith_mux !== 2'd0 || alu_output_mux !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: rv=%b rd=%h rdy=%b alu=%b/%b/%h/%h required all zero",
               resp_valid, resp_data, req_ready, alu_arith_mux, alu_output_mux, alu_rs, alu_rt);
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (resp_valid !== '0 || req_ready !== '0) bad_idle++;
    end
    n_cmp++;
    if (bad_idle != 0) begin
      n_bad++;
      $display("FAIL idle_quiet: %0d active cycles, required 0", bad_idle);
    end
  endtask

  task automatic test_add();
    int lat;
    @(posedge clk); #1;
    f_ar[0] = 2'b00; f_om[0] = 1'b0; f_rs[0] = 8'd5; f_rt[0] = 8'd3;
    req_valid = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++; $display("FAIL add_ready: got %b required 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    f_rs[0] = 8'hAA;
    f_rt[0] = 8'h55;
    wait_resp(lat);
    n_cmp++;
    if (lat != 2 || resp_valid !== 4'b0001 || resp_data !== 8'd8) begin
      n_bad++;
      $display("FAIL add_resp: lat=%0d rv=%b rd=%0d required lat=2 rv=0001 rd=8", lat, resp_valid, resp_data);
    end
    @(negedge clk);
    n_cmp++;
    if (resp_valid !== '0 || resp_data !== 8'd8) begin
      n_bad++;
      $display("FAIL add_one_pulse_hold: rv=%b rd=%0d required rv=0000 rd=8", resp_valid, resp_data);
    end
  endtask

  task automatic test_div();
    int lat = 0;
    int unstable = 0;
    @(posedge clk); #1;
    f_ar[1] = 2'b11; f_om[1] = 1'b0; f_rs[1] = 8'd20; f_rt[1] = 8'd6;
    req_valid = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL div_ready: got %b required 0010", req_ready);
    end
    @(posedge clk); #1 req_valid = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (|resp_valid) begin
        lat = k;
        break;
      end
      if (alu_arith_mux !== 2'b11 || alu_output_mux !== 1'b0 || alu_rs !== 8'd20 || alu_rt !== 8'd6)
        unstable++;
    end
    n_cmp++;
    if (lat != 2 + DIV_W || resp_valid !== 4'b0010 || resp_data !== 8'd3) begin
      n_bad++;
      $display("FAIL div_resp: lat=%0d rv=%b rd=%0d required lat=%0d rv=0010 rd=3",
               lat, resp_valid, resp_data, 2 + DIV_W);
    end
    n_cmp++;
    if (unstable != 0) begin
      n_bad++; $display("FAIL div_alu_stable: %0d bad EXEC cycles, required 0", unstable);
    end
    @(negedge clk);
    n_cmp++;
    if (alu_rs !== 8'd0 || alu_rt !== 8'd0 || alu_arith_mux !== 2'd0) begin
      n_bad++;
      $display("FAIL alu_zero_idle: alu=%b/%h/%h required zero", alu_arith_mux, alu_rs, alu_rt);
    end
  endtask

  task automatic test_compare();
    int lat;
    @(posedge clk); #1;
    f_ar[3] = 2'b11; f_om[3] = 1'b1; f_rs[3] = 8'd7; f_rt[3] = 8'd7;
    req_valid = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_bad++; $display("FAIL cmp_ready: got %b required 1000", req_ready);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_resp(lat);
    n_cmp++;
    if (lat != 2 || resp_valid !== 4'b1000 || resp_data !== 8'b00000010) begin
      n_bad++;
      $display("FAIL cmp_resp: lat=%0d rv=%b rd=%b required lat=2 rv=1000 rd=00000010", lat, resp_valid, resp_data);
    end
  endtask

  task automatic test_fairness();
    int ptr_m = 0;
    int g = 0;
    int r = 0;
    int last = -1;
    int w, o;
    int owners[$];
    logic [N-1:0] exp_v;
    do_reset();
    for (int i = 0; i < N; i++) begin
      f_ar[i] = 2'b00; f_om[i] = 1'b0; f_rs[i] = 8'($urandom); f_rt[i] = 8'($urandom);
    end
    req_valid = '1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      if (|resp_valid) begin
        n_cmp++;
        if (owners.size() == 0) begin
          n_bad++; $display("FAIL fair_resp: unexpected rv=%b", resp_valid);
        end else begin
          o = owners.pop_front();
          exp_v = '0; exp_v[o] = 1'b1;
          if (resp_valid !== exp_v || resp_data !== alu_fn(2'b00, 1'b0, f_rs[o], f_rt[o])) begin
            n_bad++;
            $display("FAIL fair_resp: rv=%b rd=%h required rv=%b rd=%h",
                     resp_valid, resp_data, exp_v, alu_fn(2'b00, 1'b0, f_rs[o], f_rt[o]));
          end
        end
        r++;
      end
      if (|req_ready) begin
        w = model_winner(req_valid, ptr_m);
        exp_v = '0;
        if (w >= 0) exp_v[w] = 1'b1;
        n_cmp++;
        if (req_ready !== exp_v) begin
          n_bad++; $display("FAIL fair_grant: grant #%0d got %b required %b", g, req_ready, exp_v);
        end
        if (last >= 0) begin
          n_cmp++;
          if (cyc - last != 3) begin
            n_bad++; $display("FAIL fair_spacing: %0d cycles between grants, required 3", cyc - last);
          end
        end
        last = cyc;
        owners.push_back(w);
        ptr_m = (w + 1) % N;
        g++;
        if (g == 5) begin
          @(posedge clk); #1 req_valid = '0;
        end
      end
    end
    n_cmp++;
    if (g != 5 || r != 5) begin
      n_bad++; $display("FAIL fair_count: grants=%0d resps=%0d required 5/5", g, r);
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    int lat;
    do_reset();
    f_ar[2] = 2'b11; f_om[2] = 1'b0; f_rs[2] = 8'd100; f_rt[2] = 8'd7;
    req_valid = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++; $display("FAIL abort_ready: got %b required 0100", req_ready);
    end
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    n_cmp++;
    if (alu_arith_mux !== 2'b11 || alu_rs !== 8'd100) begin
      n_bad++; $display("FAIL abort_exec: alu=%b/%0d required 11/100", alu_arith_mux, alu_rs);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (alu_rs !== 8'd0 || alu_arith_mux !== 2'd0 || resp_data !== 8'd0 || resp_valid !== '0) begin
      n_bad++;
      $display("FAIL abort_async: alu=%b/%h rd=%h rv=%b required zero", alu_arith_mux, alu_rs, resp_data, resp_valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (|resp_valid) seen++;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    f_ar[1] = 2'b00; f_om[1] = 1'b0; f_rs[1] = 8'd9;  f_rt[1] = 8'd4;
    f_ar[3] = 2'b01; f_om[3] = 1'b0; f_rs[3] = 8'd50; f_rt[3] = 8'd1;
    req_valid = 4'b1010;
    @(negedge clk);
    if (|resp_valid) seen++;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++; $display("FAIL abort_next_grant: got %b required 0010", req_ready);
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL abort_no_resp: %0d resp_valid cycles, required 0", seen);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_resp(lat);
    n_cmp++;
    if (lat != 2 || resp_valid !== 4'b0010 || resp_data !== 8'd13) begin
      n_bad++;
      $display("FAIL abort_after: lat=%0d rv=%b rd=%0d required lat=2 rv=0010 rd=13", lat, resp_valid, resp_data);
    end
  endtask

  task automatic test_random();
    exp_t exp_q[$];
    exp_t e;
    int ptr_m = 0;
    int pend = -1;
    int w;
    logic [N-1:0] exp_rdy, exp_rv;
    logic resp_seen;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (pend >= 0) begin
        req_valid[pend] = 1'b0;
        rand_fields(pend);
        pend = -1;
      end
      if (cyc < 340) begin
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
            rand_fields(i);
            req_valid[i] = 1'b1;
          end
        end
      end
      @(negedge clk);
      resp_seen = 1'b0;
      if (|resp_valid) begin
        resp_seen = 1'b1;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rnd_resp: unexpected rv=%b at cycle %0d", resp_valid, cyc);
        end else begin
          e = exp_q.pop_front();
          exp_rv = '0; exp_rv[e.owner] = 1'b1;
          if (resp_valid !== exp_rv || resp_data !== e.data || cyc != e.due) begin
            n_bad++;
            $display("FAIL rnd_resp: cyc=%0d rv=%b rd=%h required cyc=%0d rv=%b rd=%h",
                     cyc, resp_valid, resp_data, e.due, exp_rv, e.data);
          end
        end
      end
      exp_rdy = '0;
      w = -1;
      if (exp_q.size() == 0 && !resp_seen) begin
        w = model_winner(req_valid, ptr_m);
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      n_cmp++;
      if (req_ready !== exp_rdy) begin
        n_bad++; $display("FAIL rnd_ready: cyc=%0d got %b required %b", cyc, req_ready, exp_rdy);
      end
      if (w >= 0) begin
        e.owner = w;
        e.data  = alu_fn(f_ar[w], f_om[w], f_rs[w], f_rt[w]);
        e.due   = cyc + lat_of(f_ar[w], f_om[w]);
        exp_q.push_back(e);
        ptr_m = (w + 1) % N;
        pend  = w;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL rnd_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    req_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      f_ar[i] = '0; f_om[i] = 1'b0; f_rs[i] = '0; f_rt[i] = '0;
    end
    test_reset();
    test_add();
    test_div();
    test_compare();
    test_fairness();
    test_reset_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
